// File: rtl/tag_gpio_bit_rx_if.sv
// Receive-side report bundle: frame-start permission in, decoded word and strobe out.
interface tag_gpio_bit_rx_if #(
  parameter int TX_BITS_WIDTH = 128,
  parameter int BIT_CNT_WIDTH = 7
);
  logic                     enable;
  logic [TX_BITS_WIDTH-1:0] rx_bits;
  logic [BIT_CNT_WIDTH-1:0] rx_bits_cnt;
  logic                     rx_valid;
  logic                     rx_err;
  logic                     rx_busy;

  modport master (input enable, output rx_bits, rx_bits_cnt, rx_valid, rx_err, rx_busy);
  modport slave  (output enable, input rx_bits, rx_bits_cnt, rx_valid, rx_err, rx_busy);
endinterface

// File: rtl/tag_gpio_bit_rx.sv
// Hop-clocked GPIO bit receiver: assembles up to FRAME_BITS bits per frame from fp_gpio_in.
// Latency: pin edge to bit stored 3 clk, one-cycle rx_valid strobe next cycle; no backpressure.
module tag_gpio_bit_rx #(
  parameter int REG_WIDTH     = 12,
  parameter int TX_BITS_WIDTH = 128,
  parameter int BIT_CNT_WIDTH = 7,
  parameter int FRAME_BITS    = 80,
  parameter int CLK_PIN       = 0,
  parameter int DATA_PIN      = 1,
  parameter int RST_PIN       = 2,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int TIMEOUT       = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_WIDTH-1:0] fp_gpio_in,
  output logic [REG_WIDTH-1:0] fp_gpio_ddr,
  tag_gpio_bit_rx_if.master    rx
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  // {rst, data, clk} pin samples
  logic [2:0] sync1, sync2;
  logic       clk_prev;
  logic       hop_edge, hop_data, hop_rst;

  state_t                   state, next_state;
  logic [TX_BITS_WIDTH-1:0] work, work_nxt;
  logic [BIT_CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                     err, err_nxt;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt, idle_nxt;
  logic                     unused_pins;

  assign fp_gpio_ddr = '0;
  assign unused_pins = ^fp_gpio_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      clk_prev <= 1'b0;
    end else begin
      sync1    <= {fp_gpio_in[RST_PIN], fp_gpio_in[DATA_PIN], fp_gpio_in[CLK_PIN]};
      sync2    <= sync1;
      clk_prev <= sync2[0];
    end
  end

  assign hop_edge = sync2[0] & ~clk_prev;
  assign hop_data = sync2[1];
  assign hop_rst  = sync2[2];

  always_comb begin
    next_state = state;
    work_nxt   = work;
    cnt_nxt    = cnt;
    err_nxt    = err;
    idle_nxt   = '0;
    case (state)
      IDLE: begin
        if (hop_edge && rx.enable && !hop_rst) begin
          work_nxt    = '0;
          work_nxt[0] = hop_data;
          cnt_nxt     = BIT_CNT_WIDTH'(1);
          next_state  = (FRAME_BITS == 1) ? DONE : RECV;
        end
      end
      RECV: begin
        // Hop reset beats a coincident edge; that edge's bit is discarded.
        if (hop_rst) begin
          err_nxt    = 1'b1;
          next_state = DONE;
        end else if (hop_edge) begin
          work_nxt[cnt] = hop_data;
          cnt_nxt       = cnt + 1'b1;
          if (cnt_nxt == BIT_CNT_WIDTH'(FRAME_BITS)) next_state = DONE;
        end else if (idle_cnt == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
          err_nxt    = 1'b1;
          next_state = DONE;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
        work_nxt   = '0;
        cnt_nxt    = '0;
        err_nxt    = 1'b0;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      work     <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state    <= next_state;
      work     <= work_nxt;
      cnt      <= cnt_nxt;
      err      <= err_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // Report registers load on DONE entry and hold until the next frame ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx.rx_bits     <= '0;
      rx.rx_bits_cnt <= '0;
      rx.rx_err      <= 1'b0;
    end else if (next_state == DONE && state != DONE) begin
      rx.rx_bits     <= work_nxt;
      rx.rx_bits_cnt <= cnt_nxt;
      rx.rx_err      <= err_nxt;
    end
  end

  assign rx.rx_valid = (state == DONE);
  assign rx.rx_busy  = (state == RECV);

endmodule

// File: doc/tag_gpio_bit_rx.md
# tag_gpio_bit_rx

Serial bit receiver for the tag-chip link: it is the receiving end of the hop-clocked bit stream that the MTX tag-chip controller drives out on front-panel GPIO. It synchronizes the hop clock, data and hop-reset pins from `fp_gpio_in` and samples data on each hop-clock rising edge. Received bits are assembled into a `TX_BITS_WIDTH` word, and each completed, short or aborted frame is reported with a one-cycle strobe. It sits next to the GPIO mux in the receive-side main_anc design.

## Interface
- `REG_WIDTH`, 12, GPIO bank width
- `TX_BITS_WIDTH`, 128, received word width
- `BIT_CNT_WIDTH`, 7, bit-count width
- `FRAME_BITS`, 80, bits per full frame; legal range 1..127
- `CLK_PIN`, 0, `fp_gpio_in` index of the hop clock
- `DATA_PIN`, 1, `fp_gpio_in` index of the data line
- `RST_PIN`, 2, `fp_gpio_in` index of hop reset (active high)
- `TIMEOUT_WIDTH`, 16, idle-counter width
- `TIMEOUT`, 4096, clk cycles without a hop edge that end a frame
- `clk`  in  1  system clock; single clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `fp_gpio_in`  in  REG_WIDTH  raw front-panel pins (asynchronous)
- `fp_gpio_ddr`  out  REG_WIDTH  constant all-zero (all pins are inputs)
- `enable`  in  1  permits a new frame to start
- `rx_bits`  out  TX_BITS_WIDTH  last reported word; bit k holds the k-th received bit
- `rx_bits_cnt`  out  BIT_CNT_WIDTH  number of valid bits in `rx_bits`
- `rx_valid`  out  1  one-cycle strobe when `rx_bits`/`rx_bits_cnt` update
- `rx_err`  out  1  qualifies `rx_valid`: 1 = short frame (timeout) or abort
- `rx_busy`  out  1  high while in RECV

## Operation
- Each of the three used pins passes through a two-flop synchronizer and then one more register for edge detection.
- A hop edge is synchronized CLK high while the previous registered value is low.
- Data is taken from the synchronized DATA sample of the same cycle.
- States:
  - IDLE: the working register and count are 0. A hop edge with `enable`=1 and sync RST=0 stores bit 0 and goes to RECV with count=1. If FRAME_BITS=1, it goes straight to DONE.
  - RECV: each hop edge writes `work[count]` = data and increments count. When the new count equals FRAME_BITS, go to DONE.
  - RECV timeout: the idle counter clears on every edge and increments otherwise. On reaching TIMEOUT-1, go to DONE with the err flag set.
  - RECV abort: sync RST=1 goes to DONE with the err flag set and keeps the current count. RST wins over a simultaneous hop edge, and that edge is not stored.
  - DONE: lasts one cycle. `rx_valid`=1, `rx_bits`=work, `rx_bits_cnt`=count, `rx_err`=err flag. Then go to IDLE and clear work, count and the err flag.
- Hop edges in DONE are dropped.
- `enable` only gates the IDLE->RECV transition. Deasserting it mid-frame does not stop the frame.
- Sync RST=1 in IDLE blocks frame start.
- Bits above `rx_bits_cnt` in `rx_bits` are 0.
- `rx_bits` and `rx_bits_cnt` hold their values until the next DONE.

## Timing
- Reset values: `rx_bits`=0, `rx_bits_cnt`=0, `rx_valid`=0, `rx_err`=0, `rx_busy`=0, `fp_gpio_ddr`=0, state IDLE, all synchronizers 0.
- Pin edge to bit stored: 3 clk cycles (two synchronizer stages plus the edge register).
- Last-bit store to `rx_valid`: `rx_valid` is high during the clk cycle that immediately follows the cycle in which the last bit is stored, i.e. 4 cycles after the final pin edge.
- Timeout: `rx_valid` occurs TIMEOUT cycles after the last stored edge.
- Hop clock high and low phases must each last at least 3 clk cycles; narrower pulses are not guaranteed to be detected.
- DATA must be stable from 3 cycles before to 1 cycle after the CLK rising edge at the pins.
- `reset_n` low at any time returns all state and outputs to reset values on the next evaluation, without waiting for a clock. No `rx_valid` is issued for the interrupted frame.

## Test plan
- 80-bit pattern 0x0AAAAAAAAAAAAAAAAAAA sent LSB first with a hop period of 10 clk cycles and `enable`=1: exactly one `rx_valid` pulse, with `rx_bits`[79:0] = that pattern, upper bits 0, `rx_bits_cnt`=80 and `rx_err`=0. The pulse occurs 4 cycles after the 80th edge.
- 10 bits 0x3A5 then the hop clock stops, with TIMEOUT=64: `rx_valid` with `rx_err`=1, `rx_bits_cnt`=10 and `rx_bits`=0x3A5, 64 cycles after the 10th stored edge.
- RST pin raised after 40 bits, coincident with the 41st hop edge: abort `rx_valid` with `rx_err`=1, `rx_bits_cnt`=40 and bit 40 not stored.
- `enable`=0 during a full 80-bit burst, then `enable`=1 for a second burst: no strobe for the first burst; the second burst decodes correctly.
- `reset_n` pulsed low after 30 bits, then a fresh 80-bit frame: all outputs read 0 during reset, no strobe for the partial frame, and the new frame decodes with count 80.
- FRAME_BITS=127 with all-ones data: `rx_bits`[126:0] all 1, bit 127 = 0, `rx_bits_cnt`=127, `rx_err`=0; the count does not wrap.
